barrett_share_arbiter: RTL and testbench
========================================

# barrett_share_arbiter

Round-robin arbiter and sequencer that shares one Barrett reduction unit (enable/done, 16-bit in, 12-bit out) among several requesters, such as the per-polynomial reduce lanes of a KYBER_K polyvec. Each requester presents one coefficient at a time. The block grants access fairly, drives the reducer, and returns the result tagged with the requester ID. A watchdog detects a reducer that never signals done and latches a fault.

## Interface
- NUM_REQ, 3, number of requesters (2..4)
- I_W, 16, input coefficient width
- O_W, 12, reduced coefficient width
- ID_W, 2, requester ID width; 2^ID_W >= NUM_REQ
- TIMEOUT, 64, maximum WAIT cycles before fault (>= 2)

- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester request level
- req_coeff  in  NUM_REQ*I_W  requester k's coefficient at bits [k*I_W +: I_W]
- gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  ID_W  requester that owns the result
- rsp_coeff  out  O_W  reduced coefficient
- br_enable  out  1  one-cycle start pulse to the reducer
- br_coeff  out  I_W  reducer operand
- br_done  in  1  reducer completion pulse
- br_result  in  O_W  reducer output, valid while br_done is high
- busy  out  1  high in WAIT
- fault  out  1  sticky watchdog fault
- ops_cnt  out  16  completed operations, wraps 0xFFFF to 0

## Operation
- States are IDLE, WAIT and FAULT. The state register and all outputs are registered.
- **IDLE**
  - If any req bit is high, pick the winner: the first set bit scanning from ptr upward, wrapping modulo NUM_REQ.
  - Next edge: gnt[winner]=1, br_enable=1, br_coeff=req_coeff[winner], owner=winner, ptr=(winner+1) mod NUM_REQ, wdog=0, go to WAIT.
  - If no req bit is high, stay in IDLE.
- **WAIT**
  - gnt=0 and br_enable=0. New req is not sampled.
  - wdog increments each cycle.
  - If br_done: rsp_valid=1, rsp_id=owner, rsp_coeff=br_result, ops_cnt+1, go to IDLE.
  - Else if wdog==TIMEOUT-1: fault=1, go to FAULT.
  - If br_done and timeout coincide, br_done wins and no fault is raised.
- **FAULT**
  - Absorbing state. No grants, no responses, br_done ignored. Exit only via reset_n.
- br_done seen in IDLE is ignored and produces no response.
- Requester rules:
  - Hold req high and req_coeff stable until gnt[k] is seen.
  - req high in the gnt cycle or later is a new request.
  - Dropping req before gnt withdraws the request.
- ptr is 0 after reset.
- Fairness: a requester with req held high waits at most NUM_REQ-1 other grants.
- Widths: br_coeff is a straight copy of the selected I_W slice. rsp_coeff is a straight copy of br_result. No arithmetic is done in this block.

## Timing
- Reset values:
  - Outputs: gnt=0, rsp_valid=0, rsp_id=0, rsp_coeff=0, br_enable=0, br_coeff=0, busy=0, fault=0, ops_cnt=0.
  - Internal: ptr=0, state=IDLE.
- Grant latency: req sampled high at edge E gives gnt and br_enable high in the cycle after E.
- br_enable and gnt are asserted together for exactly one cycle.
- Response latency: br_done sampled high at edge D gives rsp_valid high in the cycle after D, for one cycle.
- Throughput: one operation per (reducer latency + 2) cycles. There is no back-to-back issue.
- The IDLE cycle after a response samples req again. ptr has already advanced.
- Asserting reset_n low mid-operation aborts immediately to the reset values. A later br_done from the aborted operation arrives in IDLE and is ignored.

## Test plan
- **Single request:** reducer model with latency 3; req=001, coeff0=5000.
  - gnt=001 one cycle after req; br_coeff=5000.
  - rsp_valid with rsp_id=0 and rsp_coeff=1671 one cycle after br_done; ops_cnt=1.
- **Round-robin:** req=111 held, coeffs 3329, 6658, 100.
  - Grants in order 0, 1, 2, 0.
  - Results 0/0, 1/0, 2/100.
  - No gnt between issue and response.
- **Fairness after pointer advance:** grant requester 1 alone, then req=011.
  - Next grant goes to 0; the scan starts from ptr=2 and wraps.
- **Watchdog:** reducer never asserts done, TIMEOUT=8.
  - fault=1 after 8 WAIT cycles; no rsp_valid.
  - Later req and br_done are ignored until reset_n.
- **Coincident done and timeout:** br_done on the final WAIT cycle.
  - Normal response, fault stays 0.
  - A stray br_done in IDLE produces no rsp_valid.
- **Reset mid-WAIT:** reset_n pulsed low after issue.
  - All outputs return to reset values; ops_cnt=0.
  - The aborted operation's br_done is ignored.
  - Next request is served normally from ptr=0.

Source files
------------

// File: rtl/barrett_share_arbiter.sv
// Round-robin arbiter that time-shares one Barrett reducer among NUM_REQ requesters.
// Results come back tagged with the owner ID; a watchdog latches a sticky fault.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | sample req, issue the round-robin winner to the reducer
// WAIT  | operation in flight, waiting for br_done or the watchdog
// FAULT | reducer timed out; absorbing until reset_n
module barrett_share_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int I_W     = 16,
    parameter int O_W     = 12,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*I_W-1:0] req_coeff,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [O_W-1:0]         rsp_coeff,
    output logic                   br_enable,
    output logic [I_W-1:0]         br_coeff,
    input  logic                   br_done,
    input  logic [O_W-1:0]         br_result,
    output logic                   busy,
    output logic                   fault,
    output logic [15:0]            ops_cnt
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam int CW   = ID_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] owner;
    logic [WD_W-1:0] wdog;

    logic            found;
    logic [ID_W-1:0] winner;
    logic [CW-1:0]   cand;
    logic [ID_W-1:0] ptr_next;

    // Scan from ptr upward, wrapping modulo NUM_REQ; one spare bit holds the unwrapped sum.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(NUM_REQ))
                cand = cand - CW'(NUM_REQ);
            if (!found && req[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

    assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            wdog      <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_coeff <= '0;
            br_enable <= 1'b0;
            br_coeff  <= '0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            ops_cnt   <= '0;
        end else begin
            gnt       <= '0;
            br_enable <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        gnt       <= NUM_REQ'(1) << winner;
                        br_enable <= 1'b1;
                        br_coeff  <= req_coeff[winner*I_W +: I_W];
                        owner     <= winner;
                        ptr       <= ptr_next;
                        wdog      <= '0;
                        busy      <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A done on the last watchdog cycle still counts as a normal completion.
                    if (br_done) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= owner;
                        rsp_coeff <= br_result;
                        ops_cnt   <= ops_cnt + 16'd1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        fault <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_FAULT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_share_arbiter.sv
// Directed bench for barrett_share_arbiter: vector table of grant/response
// transactions plus hand-written watchdog, coincidence and reset sequences.
module tb_barrett_share_arbiter;

    localparam int NUM_REQ = 3;
    localparam int I_W     = 16;
    localparam int O_W     = 12;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 8;
    localparam int LAT     = 3;

    logic                   clk;
    logic                   reset_n;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*I_W-1:0] req_coeff;
    logic [NUM_REQ-1:0]     gnt;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [O_W-1:0]         rsp_coeff;
    logic                   br_enable;
    logic [I_W-1:0]         br_coeff;
    logic                   br_done;
    logic [O_W-1:0]         br_result;
    logic                   busy;
    logic                   fault;
    logic [15:0]            ops_cnt;

    int n_total = 0;
    int n_pass  = 0;

    barrett_share_arbiter #(
        .NUM_REQ(NUM_REQ), .I_W(I_W), .O_W(O_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_coeff(req_coeff),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_coeff(rsp_coeff),
        .br_enable(br_enable), .br_coeff(br_coeff), .br_done(br_done),
        .br_result(br_result), .busy(busy), .fault(fault), .ops_cnt(ops_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reducer model: done LAT negedges after the enable is seen, result = coeff mod q.
    logic        model_en = 1'b0;
    int          mdl_cnt  = 0;
    logic [15:0] mdl_held = '0;
    always @(negedge clk) begin
        if (model_en) begin
            br_done = 1'b0;
            if (mdl_cnt > 0) begin
                mdl_cnt = mdl_cnt - 1;
                if (mdl_cnt == 0) begin
                    br_done   = 1'b1;
                    br_result = 12'(mdl_held % 16'd3329);
                end
            end
            if (br_enable) begin
                mdl_cnt  = LAT;
                mdl_held = br_coeff;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},       32'(gnt),       32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        check({tag, "_rsp_coeff"}, 32'(rsp_coeff), 32'd0);
        check({tag, "_br_enable"}, 32'(br_enable), 32'd0);
        check({tag, "_br_coeff"},  32'(br_coeff),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_fault"},     32'(fault),     32'd0);
        check({tag, "_ops_cnt"},   32'(ops_cnt),   32'd0);
    endtask

    // Returns the number of negedges until gnt appears (0 if none within budget).
    task automatic wait_gnt(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (gnt != '0) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_txn(input logic [2:0] r, input logic [15:0] c0, input logic [15:0] c1,
                          input logic [15:0] c2, input int exp_id, input logic [11:0] exp_rsp,
                          input int exp_ops);
        int          lat;
        int          rlat;
        int          extra;
        logic [15:0] exp_br;
        exp_br    = (exp_id == 0) ? c0 : (exp_id == 1) ? c1 : c2;
        req_coeff = {c2, c1, c0};
        req       = r;
        wait_gnt(lat);
        if (lat == 0) return;
        check("gnt_latency", 32'(lat),       32'd1);
        check("gnt_onehot",  32'(gnt),       32'(3'b001 << exp_id));
        check("br_enable",   32'(br_enable), 32'd1);
        check("br_coeff",    32'(br_coeff),  32'(exp_br));
        check("busy_wait",   32'(busy),      32'd1);
        rlat  = 0;
        extra = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (gnt != '0 || br_enable) extra++;
            if (rsp_valid) begin
                rlat = k;
                break;
            end
        end
        if (rlat == 0) begin
            check("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        check("rsp_latency",  32'(rlat),      32'(LAT + 1));
        check("gnt_in_wait",  32'(extra),     32'd0);
        check("rsp_id",       32'(rsp_id),    32'(exp_id));
        check("rsp_coeff",    32'(rsp_coeff), 32'(exp_rsp));
        check("ops_cnt",      32'(ops_cnt),   32'(exp_ops));
        check("busy_idle",    32'(busy),      32'd0);
    endtask

    typedef struct {
        logic [2:0]  r;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [15:0] c2;
        int          exp_id;
        logic [11:0] exp_rsp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int   lat;
        int   bad_gnt;
        int   bad_rsp;

        vecs[0] = '{3'b111, 16'd3329, 16'd6658, 16'd100,   0, 12'd0};
        vecs[1] = '{3'b111, 16'd3329, 16'd6658, 16'd100,   1, 12'd0};
        vecs[2] = '{3'b111, 16'd3329, 16'd6658, 16'd100,   2, 12'd100};
        vecs[3] = '{3'b111, 16'd3329, 16'd6658, 16'd100,   0, 12'd0};
        vecs[4] = '{3'b001, 16'd5000, 16'd0,    16'd0,     0, 12'd1671};
        vecs[5] = '{3'b010, 16'd0,    16'd1234, 16'd0,     1, 12'd1234};
        vecs[6] = '{3'b011, 16'd4000, 16'd9,    16'd0,     0, 12'd671};
        vecs[7] = '{3'b100, 16'd0,    16'd0,    16'd65535, 2, 12'd2284};

        reset_n   = 1'b0;
        req       = '0;
        req_coeff = '0;
        br_done   = 1'b0;
        br_result = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n  = 1'b1;
        model_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i].r, vecs[i].c0, vecs[i].c1, vecs[i].c2,
                   vecs[i].exp_id, vecs[i].exp_rsp, i + 1);
        req = '0;
        repeat (2) @(negedge clk);

        // Done on the final watchdog cycle wins over the timeout.
        model_en  = 1'b0;
        br_done   = 1'b0;
        req_coeff = {16'd0, 16'd0, 16'd777};
        req       = 3'b001;
        wait_gnt(lat);
        req = '0;
        check("coinc_gnt", 32'(gnt), 32'd1);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("coinc_busy_last", 32'(busy), 32'd1);
        br_done   = 1'b1;
        br_result = 12'd777;
        @(negedge clk);
        br_done = 1'b1;
        check("coinc_rsp_valid", 32'(rsp_valid), 32'd1);
        check("coinc_rsp_coeff", 32'(rsp_coeff), 32'd777);
        check("coinc_fault",     32'(fault),     32'd0);
        check("coinc_ops",       32'(ops_cnt),   32'd9);
        @(negedge clk);
        br_done = 1'b0;
        check("stray_done_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("stray_done_rsp2", 32'(rsp_valid), 32'd0);
        check("stray_done_ops",  32'(ops_cnt),   32'd9);

        // Watchdog: reducer never answers.
        req_coeff = {16'd0, 16'd42, 16'd0};
        req       = 3'b010;
        wait_gnt(lat);
        req = '0;
        check("wd_gnt", 32'(gnt), 32'b010);
        bad_rsp = 0;
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            @(negedge clk);
            if (rsp_valid) bad_rsp++;
        end
        check("wd_fault_early", 32'(fault), 32'd0);
        check("wd_busy_early",  32'(busy),  32'd1);
        @(negedge clk);
        check("wd_fault",   32'(fault),     32'd1);
        check("wd_busy",    32'(busy),      32'd0);
        check("wd_no_rsp",  32'(bad_rsp + 32'(rsp_valid)), 32'd0);
        bad_gnt = 0;
        bad_rsp = 0;
        req     = 3'b111;
        for (int k = 0; k < 10; k++) begin
            br_done = k[0];
            @(negedge clk);
            if (gnt != '0 || br_enable) bad_gnt++;
            if (rsp_valid) bad_rsp++;
        end
        br_done = 1'b0;
        req     = '0;
        check("fault_no_gnt",  32'(bad_gnt), 32'd0);
        check("fault_no_rsp",  32'(bad_rsp), 32'd0);
        check("fault_sticky",  32'(fault),   32'd1);
        check("fault_ops",     32'(ops_cnt), 32'd9);

        // Reset clears the fault; then abort an operation mid-WAIT.
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("fault_reset");
        reset_n  = 1'b1;
        model_en = 1'b1;
        @(negedge clk);
        req_coeff = {16'd0, 16'd500, 16'd0};
        req       = 3'b010;
        wait_gnt(lat);
        req = '0;
        check("abort_gnt", 32'(gnt), 32'b010);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort_reset");
        reset_n = 1'b1;
        bad_rsp = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) bad_rsp++;
        end
        check("abort_done_ignored", 32'(bad_rsp), 32'd0);
        check("abort_ops",          32'(ops_cnt), 32'd0);
        do_txn(3'b110, 16'd0, 16'd3400, 16'd9999, 1, 12'd71, 1);
        req = '0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
